// File: rtl/max7219_receiver.sv
// Slave-side model of a chain of SIZE MAX7219 drivers: deserialises the sclk/mosi/cs stream,
// decodes the per-device address/data words and holds each device's register file.
module max7219_receiver #(
    parameter int unsigned SIZE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                mosi,
    input  logic                cs,
    output logic                dout,
    output logic [64*SIZE-1:0]  pixels,
    output logic [4*SIZE-1:0]   intensity,
    output logic [3*SIZE-1:0]   scan_limit,
    output logic [8*SIZE-1:0]   decode_mode,
    output logic [SIZE-1:0]     shutdown_n,
    output logic [SIZE-1:0]     display_test,
    output logic                update,
    output logic                frame_err
);

    localparam int unsigned FRAME_BITS = 16 * SIZE;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    // Synchronisers plus one history flop each for edge detection
    logic sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic cs_s1_q, cs_s2_q, cs_h_q;
    logic mosi_s1_q, mosi_s2_q;

    logic sclk_rise;
    logic cs_rise;
    logic cs_fall;
    logic shift_en;

    logic [FRAME_BITS-1:0] shreg_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [7:0] addr_w [SIZE];
    logic [7:0] data_w [SIZE];
    logic       frame_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_h_q  <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_h_q    <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            cs_s1_q   <= cs;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    always_comb begin
        sclk_rise = sclk_s2_q & ~sclk_h_q;
        cs_rise   = cs_s2_q & ~cs_h_q;
        cs_fall   = ~cs_s2_q & cs_h_q;
        shift_en  = sclk_rise & ~cs_s2_q;
    end

    // Counter restarts on cs fall and saturates one past a full frame so overruns stay visible
    always_comb begin
        cnt_d = cnt_q;
        if (cs_fall) begin
            cnt_d = '0;
        end
        if (shift_en && (cnt_d != CNT_SAT)) begin
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            dout    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (shift_en) begin
                shreg_q <= {shreg_q[FRAME_BITS-2:0], mosi_s2_q};
                dout    <= shreg_q[FRAME_BITS-1];
            end
        end
    end

    // Device 0 owns the least-significant word, i.e. the last 16 bits shifted in
    always_comb begin
        for (int i = 0; i < int'(SIZE); i++) begin
            addr_w[i] = shreg_q[16*i+8 +: 8];
            data_w[i] = shreg_q[16*i +: 8];
        end
        frame_ok = cs_rise && (cnt_q == CNT_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixels       <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            decode_mode  <= '0;
            shutdown_n   <= '0;
            display_test <= '0;
            update       <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            update    <= frame_ok;
            frame_err <= cs_rise && !frame_ok;
            if (frame_ok) begin
                for (int i = 0; i < int'(SIZE); i++) begin
                    for (int k = 0; k < 8; k++) begin
                        if (addr_w[i] == 8'(k + 1)) begin
                            pixels[64*i+63-8*k -: 8] <= data_w[i];
                        end
                    end
                    case (addr_w[i])
                        8'h09:   decode_mode[8*i +: 8] <= data_w[i];
                        8'h0A:   intensity[4*i +: 4]   <= data_w[i][3:0];
                        8'h0B:   scan_limit[3*i +: 3]  <= data_w[i][2:0];
                        8'h0C:   shutdown_n[i]         <= data_w[i][0];
                        8'h0F:   display_test[i]       <= data_w[i][0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_max7219_receiver.sv
// Directed bench for max7219_receiver (SIZE=2): frames are driven over sclk/mosi/cs and every
// update/frame_err pulse is checked against a queued, hand-computed register snapshot.
module tb_max7219_receiver;

    localparam int unsigned SIZE = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                sclk;
    logic                mosi;
    logic                cs;
    logic                dout;
    logic [64*SIZE-1:0]  pixels;
    logic [4*SIZE-1:0]   intensity;
    logic [3*SIZE-1:0]   scan_limit;
    logic [8*SIZE-1:0]   decode_mode;
    logic [SIZE-1:0]     shutdown_n;
    logic [SIZE-1:0]     display_test;
    logic                update;
    logic                frame_err;

    max7219_receiver #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .mosi         (mosi),
        .cs           (cs),
        .dout         (dout),
        .pixels       (pixels),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .decode_mode  (decode_mode),
        .shutdown_n   (shutdown_n),
        .display_test (display_test),
        .update       (update),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_err;
        logic [127:0] pix;
        logic [7:0]   inten;
        logic [5:0]   scan;
        logic [15:0]  dec;
        logic [1:0]   shdn;
        logic [1:0]   test;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;

    logic [127:0] e_pix;
    logic [7:0]   e_int;
    logic [5:0]   e_scan;
    logic [15:0]  e_dec;
    logic [1:0]   e_shdn;
    logic [1:0]   e_test;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic clear_exp();
        e_pix  = '0;
        e_int  = '0;
        e_scan = '0;
        e_dec  = '0;
        e_shdn = '0;
        e_test = '0;
    endtask

    // Lowers cs (if not already low) and shifts n bits, MSB first, from bits[n-1]
    task automatic shift_bits(input logic [63:0] bits, input int n);
        cs = 1'b0;
        #50;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            #25;
            sclk = 1'b1;
            #50;
            sclk = 1'b0;
            #25;
        end
    endtask

    task automatic end_frame(input bit is_err);
        exp_t e;
        e.is_err = is_err;
        e.pix    = e_pix;
        e.inten  = e_int;
        e.scan   = e_scan;
        e.dec    = e_dec;
        e.shdn   = e_shdn;
        e.test   = e_test;
        sb.push_back(e);
        #50;
        cs = 1'b1;
        #150;
    endtask

    // Monitor: every pulse pops one expectation and compares the whole register image
    always @(negedge clk) begin
        if (!rst && (update || frame_err)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse actual update=%b frame_err=%b required=none",
                         update, frame_err);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_update", 128'(update), 128'(!mon_e.is_err));
                check("pulse_frame_err", 128'(frame_err), 128'(mon_e.is_err));
                check("pixels", pixels, mon_e.pix);
                check("intensity", 128'(intensity), 128'(mon_e.inten));
                check("scan_limit", 128'(scan_limit), 128'(mon_e.scan));
                check("decode_mode", 128'(decode_mode), 128'(mon_e.dec));
                check("shutdown_n", 128'(shutdown_n), 128'(mon_e.shdn));
                check("display_test", 128'(display_test), 128'(mon_e.test));
            end
        end
    end

    initial begin
        rst  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        cs   = 1'b1;
        clear_exp();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pixels", pixels, 128'h0);
        check("rst_intensity", 128'(intensity), 128'h0);
        check("rst_scan_limit", 128'(scan_limit), 128'h0);
        check("rst_decode_mode", 128'(decode_mode), 128'h0);
        check("rst_shutdown_n", 128'(shutdown_n), 128'h0);
        check("rst_display_test", 128'(display_test), 128'h0);
        check("rst_dout", 128'(dout), 128'h0);
        check("rst_update", 128'(update), 128'h0);
        check("rst_frame_err", 128'(frame_err), 128'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Intensity on both devices; first word lands in device 1
        shift_bits(64'h0A05_0A0C, 32);
        e_int = 8'h5C;
        end_frame(1'b0);
        check("dout_after_first_frame", 128'(dout), 128'h0);

        // Digit 0 of device 1 and digit 7 of device 0
        shift_bits(64'h01A5_0881, 32);
        e_pix[127:120] = 8'hA5;
        e_pix[7:0]     = 8'h81;
        end_frame(1'b0);

        // Short and long frames are discarded
        shift_bits(64'h1234_5678, 31);
        end_frame(1'b1);
        shift_bits(64'h1_0000_0000, 33);
        end_frame(1'b1);
        check("dout_overrun_bit", 128'(dout), 128'h1);

        // Shutdown on device 0 (device 1 noop), then display test on device 1
        shift_bits(64'h0000_0C01, 32);
        e_shdn = 2'b01;
        end_frame(1'b0);
        shift_bits(64'h0F01_0000, 32);
        e_test = 2'b10;
        end_frame(1'b0);

        // Decode mode, then ignored addresses change nothing
        shift_bits(64'h09F0_090F, 32);
        e_dec = 16'hF00F;
        end_frame(1'b0);
        shift_bits(64'h0D55_FF66, 32);
        end_frame(1'b0);

        // Reset mid-frame, then a full frame with cs still low from before the reset
        shift_bits(64'h0000_03FF, 10);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_exp();
        check("midreset_pixels", pixels, 128'h0);
        check("midreset_shutdown_n", 128'(shutdown_n), 128'h0);
        repeat (3) @(negedge clk);
        shift_bits(64'h0B07_0B03, 32);
        e_scan = 6'b111_011;
        end_frame(1'b0);

        #300;
        check("all_pulses_seen", 128'(sb.size()), 128'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
